// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad entry/display slice.
package keypad_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned CODE_W     = 4;
    localparam int unsigned COUNT_W    = 3;

    localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;
    localparam logic [CODE_W-1:0]     CLEAR_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

endpackage

// File: rtl/key_debounce_fsm.sv
// Debounces key_valid; one registered accept strobe plus latched code per press.
module key_debounce_fsm
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              key_valid,
    input  logic [CODE_W-1:0] key_code,
    output logic              accept,
    output logic [CODE_W-1:0] code
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES);
    localparam bit               SINGLE  = (DEBOUNCE_CYCLES <= 1);

    deb_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             latch_c;

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            accept <= 1'b0;
            code   <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            accept <= latch_c;
            if (latch_c) begin
                code <= key_code;
            end
        end
    end

    // Stable counter restarts at 1 whenever key_valid changes level.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch_c = 1'b0;
        cnt_inc = cnt + CNT_ONE;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    if (SINGLE) begin
                        state_n = HELD;
                        cnt_n   = '0;
                        latch_c = 1'b1;
                    end else begin
                        state_n = PRESS_WAIT;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!key_valid) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt_inc >= CNT_TOP) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    latch_c = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HELD: begin
                if (!key_valid) begin
                    if (SINGLE) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        state_n = RELEASE_WAIT;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (key_valid) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt_inc >= CNT_TOP) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: rtl/keypad_entry_display.sv
// Keypad entry buffer and 4-digit multiplexed display driver.
// Build option KEYPAD_CLEAR_KEY_EN: accepted code F clears the buffer instead of being stored.
module keypad_entry_display
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REFRESH_DIV     = 250
) (
    input  logic                  Clock,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [CODE_W-1:0]     key_code,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [CODE_W-1:0]     digit,
    output logic                  digit_blank,
    output logic [COUNT_W-1:0]    entry_count,
    output logic                  key_accept
);

    localparam int unsigned        REF_W     = $clog2(REFRESH_DIV + 1);
    localparam int unsigned        SEL_W     = $clog2(NUM_DIGITS);
    localparam logic [REF_W-1:0]   REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(NUM_DIGITS);

    logic                                accept_strobe;
    logic [CODE_W-1:0]                   latched_code;
    logic [NUM_DIGITS-1:0][CODE_W-1:0]   digits_q, digits_n;
    logic [COUNT_W-1:0]                  count_n;
    logic [REF_W-1:0]                    refresh_cnt;
    logic [SEL_W-1:0]                    sel;

    key_debounce_fsm #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .Clock    (Clock),
        .reset    (reset),
        .key_valid(key_valid),
        .key_code (key_code),
        .accept   (accept_strobe),
        .code     (latched_code)
    );

    // Next buffer contents and entry count on an accepted key.
    always_comb begin
        digits_n = {digits_q[NUM_DIGITS-2:0], latched_code};
        count_n  = (entry_count < COUNT_MAX) ? entry_count + COUNT_W'(1) : entry_count;
`ifdef KEYPAD_CLEAR_KEY_EN
        if (latched_code == CLEAR_CODE) begin
            digits_n = '0;
            count_n  = '0;
        end
`endif
    end

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            digits_q    <= '0;
            entry_count <= '0;
            key_accept  <= 1'b0;
        end else begin
            key_accept <= accept_strobe;
            if (accept_strobe) begin
                digits_q    <= digits_n;
                entry_count <= count_n;
            end
        end
    end

    // AN, digit and blank are registered together from the same sel value.
    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            refresh_cnt <= '0;
            sel         <= '0;
            AN          <= AN_ALL_OFF;
            digit       <= '0;
            digit_blank <= 1'b1;
        end else begin
            if (refresh_cnt == REF_LAST) begin
                refresh_cnt <= '0;
                sel         <= sel + SEL_W'(1);
            end else begin
                refresh_cnt <= refresh_cnt + REF_W'(1);
            end
            AN          <= ~(NUM_DIGITS'(1) << sel);
            digit       <= digits_q[sel];
            digit_blank <= (COUNT_W'(sel) >= entry_count);
        end
    end

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display: vector table plus hand-written timing sequences.
module tb_keypad_entry_display;

    localparam int unsigned DEB = 4;
    localparam int unsigned REF = 2;

    logic       Clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] AN;
    logic [3:0] digit;
    logic       digit_blank;
    logic [2:0] entry_count;
    logic       key_accept;

    int n_vec = 0;
    int n_err = 0;
    int unsigned cyc;

    keypad_entry_display #(
        .DEBOUNCE_CYCLES(DEB),
        .REFRESH_DIV    (REF)
    ) dut (
        .Clock      (Clock),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .AN         (AN),
        .digit      (digit),
        .digit_blank(digit_blank),
        .entry_count(entry_count),
        .key_accept (key_accept)
    );

    always #5 Clock = ~Clock;

    // Rising edges since the last reset release.
    always @(posedge Clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        logic        kv;
        logic [3:0]  code;
        int          cycles;
        int          exp_acc;
        logic [2:0]  exp_cnt;
        logic        chk_buf;
        logic [15:0] exp_buf;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic kv, input logic [3:0] c, input int n, output int acc);
        key_valid = kv;
        key_code  = c;
        acc = 0;
        repeat (n) begin
            @(negedge Clock);
            if (key_accept === 1'b1) acc++;
        end
    endtask

    // Scan one full refresh rotation and compare each position's digit and blank.
    task automatic check_buffer(input logic [15:0] exp_buf, input logic [2:0] exp_cnt, input string tag);
        logic [3:0] got_d [4];
        logic       got_b [4];
        logic       bad;
        int         p;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            got_d[i] = 'x;
            got_b[i] = 'x;
        end
        key_valid = 1'b0;
        repeat (2 * REF * 4) begin
            @(negedge Clock);
            p = -1;
            case (AN)
                4'b1110: p = 0;
                4'b1101: p = 1;
                4'b1011: p = 2;
                4'b0111: p = 3;
                default: bad = 1'b1;
            endcase
            if (p >= 0) begin
                got_d[p] = digit;
                got_b[p] = digit_blank;
            end
        end
        chk({tag, "_an_one_cold"}, 16'(bad), 16'h0);
        chk({tag, "_count"}, 16'(entry_count), 16'(exp_cnt));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_d%0d", tag, i), 16'(got_d[i]), 16'(exp_buf[4*i +: 4]));
            chk($sformatf("%s_blank%0d", tag, i), 16'(got_b[i]), 16'(i >= int'(exp_cnt)));
        end
    endtask

    initial begin
        int acc;
        int first_acc;
        int s;
        logic [3:0] exp_an;

        // press 3 short, bounce on press, presses 1,2,3,4,7, then 9 with release bounce
        vecs[0]  = '{1'b1, 4'h3, 3,  0, 3'd1, 1'b0, 16'h0000};
        vecs[1]  = '{1'b0, 4'h0, 6,  0, 3'd1, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 4'h4, 2,  0, 3'd1, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 4'h4, 1,  0, 3'd1, 1'b0, 16'h0000};
        vecs[4]  = '{1'b1, 4'h4, 2,  0, 3'd1, 1'b0, 16'h0000};
        vecs[5]  = '{1'b0, 4'h0, 6,  0, 3'd1, 1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 4'h1, 8,  1, 3'd2, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 4'h0, 8,  0, 3'd2, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 4'h2, 8,  1, 3'd3, 1'b0, 16'h0000};
        vecs[9]  = '{1'b0, 4'h0, 8,  0, 3'd3, 1'b0, 16'h0000};
        vecs[10] = '{1'b1, 4'h3, 8,  1, 3'd4, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 4'h0, 8,  0, 3'd4, 1'b0, 16'h0000};
        vecs[12] = '{1'b1, 4'h4, 8,  1, 3'd4, 1'b0, 16'h0000};
        vecs[13] = '{1'b0, 4'h0, 8,  0, 3'd4, 1'b0, 16'h0000};
        vecs[14] = '{1'b1, 4'h7, 8,  1, 3'd4, 1'b0, 16'h0000};
        vecs[15] = '{1'b0, 4'h0, 8,  0, 3'd4, 1'b1, 16'h2347};
        vecs[16] = '{1'b1, 4'h9, 8,  1, 3'd4, 1'b0, 16'h0000};
        vecs[17] = '{1'b0, 4'h9, 1,  0, 3'd4, 1'b0, 16'h0000};
        vecs[18] = '{1'b1, 4'h9, 1,  0, 3'd4, 1'b0, 16'h0000};
        vecs[19] = '{1'b0, 4'h9, 1,  0, 3'd4, 1'b0, 16'h0000};
        vecs[20] = '{1'b1, 4'h9, 1,  0, 3'd4, 1'b0, 16'h0000};
        vecs[21] = '{1'b0, 4'h0, 10, 0, 3'd4, 1'b1, 16'h3479};

        reset = 1'b1;
        key_valid = 1'b0;
        key_code = 4'h0;
        repeat (2) @(negedge Clock);
        chk("rst_an", 16'(AN), 16'hF);
        chk("rst_accept", 16'(key_accept), 16'h0);
        chk("rst_count", 16'(entry_count), 16'h0);
        chk("rst_digit", 16'(digit), 16'h0);
        chk("rst_blank", 16'(digit_blank), 16'h1);

        reset = 1'b0;
        @(negedge Clock);
        chk("live_an", 16'(AN), 16'hE);
        chk("live_digit", 16'(digit), 16'h0);
        chk("live_blank", 16'(digit_blank), 16'h1);

        // Long hold of code 5: exactly one accept, DEB+1 cycles after key_valid rises.
        key_valid = 1'b1;
        key_code = 4'h5;
        acc = 0;
        first_acc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if (key_accept === 1'b1) begin
                acc++;
                if (first_acc < 0) first_acc = i;
            end
        end
        chk("hold_accept_cycle", 16'(first_acc), 16'(DEB + 1));
        chk("hold_accept_count", 16'(acc), 16'd1);
        chk("hold_entry_count", 16'(entry_count), 16'd1);
        drive(1'b0, 4'h0, 8, acc);
        check_buffer(16'h0005, 3'd1, "after5");

        for (int i = 0; i < 22; i++) begin
            drive(vecs[i].kv, vecs[i].code, vecs[i].cycles, acc);
            chk($sformatf("vec%0d_acc", i), 16'(acc), 16'(vecs[i].exp_acc));
            chk($sformatf("vec%0d_count", i), 16'(entry_count), 16'(vecs[i].exp_cnt));
            if (vecs[i].chk_buf) check_buffer(vecs[i].exp_buf, vecs[i].exp_cnt, $sformatf("vec%0d", i));
        end

        // Reset in the middle of PRESS_WAIT, key still held afterwards.
        key_valid = 1'b1;
        key_code = 4'h1;
        repeat (2) @(negedge Clock);
        reset = 1'b1;
        #1;
        chk("midrst_an", 16'(AN), 16'hF);
        chk("midrst_count", 16'(entry_count), 16'h0);
        chk("midrst_accept", 16'(key_accept), 16'h0);
        @(negedge Clock);
        chk("midrst_an_held", 16'(AN), 16'hF);
        reset = 1'b0;
        acc = 0;
        first_acc = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clock);
            if (key_accept === 1'b1) begin
                acc++;
                if (first_acc < 0) first_acc = i;
            end
        end
        chk("postrst_accept_cycle", 16'(first_acc), 16'(DEB + 1));
        chk("postrst_accept_count", 16'(acc), 16'd1);
        chk("postrst_count", 16'(entry_count), 16'd1);
        drive(1'b0, 4'h0, 8, acc);
        drive(1'b1, 4'h6, 8, acc);
        chk("press6_acc", 16'(acc), 16'd1);
        drive(1'b0, 4'h0, 8, acc);
        chk("press6_count", 16'(entry_count), 16'd2);

        // Anode rotation with two digits entered; position k lit during edges 2k+1, 2k+2 of each rotation.
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            s = int'(((cyc - 1) / 2) % 4);
            exp_an = ~(4'b0001 << s);
            chk($sformatf("rot%0d_an", i), 16'(AN), 16'(exp_an));
            chk($sformatf("rot%0d_blank", i), 16'(digit_blank), 16'(s >= 2));
        end
        check_buffer(16'h0016, 3'd2, "two");

        drive(1'b1, 4'h3, 8, acc);
        drive(1'b0, 4'h0, 8, acc);
        chk("press3_count", 16'(entry_count), 16'd3);
        drive(1'b1, 4'hF, 8, acc);
        chk("pressF_acc", 16'(acc), 16'd1);
        drive(1'b0, 4'h0, 8, acc);
`ifdef KEYPAD_CLEAR_KEY_EN
        check_buffer(16'h0000, 3'd0, "clear");
`else
        check_buffer(16'h163F, 3'd4, "storeF");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
